// File: rtl/nanov_spi_mem_responder.sv
// nanov_spi_mem_responder: SPI streaming memory responder for nanoV; define SPI_MEM_WRITE_EN to enable the streaming write path
module nanov_spi_mem_responder #(
    parameter int         WORDS     = 256,
    parameter logic [7:0] READ_CMD  = 8'h03,
    parameter logic [7:0] WRITE_CMD = 8'h02
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     spi_select,
    input  logic                     spi_clk_enable,
    input  logic                     spi_data_in,
    output logic                     spi_data_out,
    input  logic                     load_en,
    input  logic [$clog2(WORDS)-1:0] load_addr,
    input  logic [31:0]              load_data,
    output logic                     busy
);
    localparam int AW = $clog2(WORDS);
    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, READ, IGNORE
`ifdef SPI_MEM_WRITE_EN
        , WRITE
`endif
    } state_t;
    state_t state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [6:0]    cmd_q, cmd_d;
    logic [AW:0]   addr_q, addr_d;
    logic [AW-1:0] idx_q, idx_d, rd_idx;
    logic [30:0]   sh_q, sh_d;
    logic          dout_q, dout_d, busy_q, busy_d;
    logic [7:0]    cmd_w;
    logic [31:0]   rd_word;
    logic [31:0]   mem_q [WORDS];
`ifdef SPI_MEM_WRITE_EN
    logic          wr_q, wr_d, commit;
    logic [30:0]   wsh_q, wsh_d;
`else
    logic          unused_ok;
    assign unused_ok = ^WRITE_CMD;
`endif
    assign cmd_w        = {cmd_q, spi_data_in};
    // Asynchronous fetch: address-complete edge reads the decoded index, streaming reads the next one
    assign rd_idx       = (state_q == ADDR) ? addr_q[AW:1] : idx_q + 1'b1;
    assign rd_word      = mem_q[rd_idx];
    assign spi_data_out = dout_q;
    assign busy         = busy_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
`ifdef SPI_MEM_WRITE_EN
        wr_d    = wr_q;
        wsh_d   = wsh_q;
        commit  = 1'b0;
`endif
        if (spi_select) begin
            state_d = IDLE;
            cnt_d   = '0;
            dout_d  = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = CMD;
            if (spi_clk_enable) begin
                cmd_d = {cmd_q[5:0], spi_data_in};
                cnt_d = 5'd1;
            end
        end else if (spi_clk_enable) begin
            cnt_d = cnt_q + 5'd1;
            case (state_q)
                CMD: begin
                    cmd_d = {cmd_q[5:0], spi_data_in};
                    if (cnt_q == 5'd7) begin
                        cnt_d = '0;
`ifdef SPI_MEM_WRITE_EN
                        wr_d    = cmd_w == WRITE_CMD;
                        state_d = (cmd_w == READ_CMD || cmd_w == WRITE_CMD) ? ADDR : IGNORE;
`else
                        state_d = (cmd_w == READ_CMD) ? ADDR : IGNORE;
`endif
                    end
                end
                ADDR: begin
                    addr_d = {addr_q[AW-1:0], spi_data_in};
                    if (cnt_q == 5'd23) begin
                        cnt_d = '0;
                        idx_d = addr_q[AW:1];
`ifdef SPI_MEM_WRITE_EN
                        state_d = wr_q ? WRITE : READ;
`else
                        state_d = READ;
`endif
                        if (state_d == READ) {sh_d, dout_d} = rd_word;
                    end
                end
                READ: begin
                    dout_d = sh_q[0];
                    sh_d   = sh_q >> 1;
                    if (cnt_q == 5'd31) begin
                        idx_d          = idx_q + 1'b1;
                        {sh_d, dout_d} = rd_word;
                    end
                end
`ifdef SPI_MEM_WRITE_EN
                WRITE: begin
                    wsh_d = {spi_data_in, wsh_q[30:1]};
                    if (cnt_q == 5'd31) begin
                        commit = 1'b1;
                        idx_d  = idx_q + 1'b1;
                    end
                end
`endif
                default: dout_d = 1'b0;
            endcase
        end
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SPI_MEM_WRITE_EN
            wr_q    <= 1'b0;
            wsh_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
`ifdef SPI_MEM_WRITE_EN
            wr_q    <= wr_d;
            wsh_q   <= wsh_d;
`endif
        end
    end
    // Backdoor load is written last so it wins a same-index collision with an SPI commit
    always_ff @(posedge clk) begin
`ifdef SPI_MEM_WRITE_EN
        if (commit) mem_q[idx_q] <= {spi_data_in, wsh_q};
`endif
        if (load_en) mem_q[load_addr] <= load_data;
    end
endmodule

// File: doc/nanov_spi_mem_responder.md
# nanov_spi_mem_responder

SPI memory responder that serves the nanoV instruction/data stream from the device side. It decodes a command byte and 24-bit address shifted in by the CPU's SPI initiator, then streams 32-bit words back bit-serially with auto-increment. It sits in the FPGA top level and in simulation benches as the program memory, clocked from the CPU clock. Transfers are qualified by the CPU's select and clock-enable strobes.

## Interface
Parameters:
- WORDS, 256, memory depth in 32-bit words; power of two.
- READ_CMD, 8'h03, command byte selecting streaming read.
- WRITE_CMD, 8'h02, command byte selecting streaming write (only with SPI_MEM_WRITE_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- spi_select  in  1  chip select, active low.
- spi_clk_enable  in  1  bit strobe; one SPI bit per clk edge while high and select low ("enabled edge").
- spi_data_in  in  1  MOSI from the CPU.
- spi_data_out  out  1  MISO to the CPU, registered.
- load_en  in  1  backdoor write strobe.
- load_addr  in  $clog2(WORDS)  backdoor word index.
- load_data  in  32  backdoor write data.
- busy  out  1  high while not in IDLE.

## Operation
- States: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
- IDLE: select high. Select low moves to CMD on the next edge with bit counter = 0. An enabled edge in that same cycle counts as CMD bit 0.
- CMD: 8 bits, MSB first.
  - After bit 7: READ_CMD or WRITE_CMD goes to ADDR.
  - Any other value goes to IGNORE.
- ADDR: 24 bits, MSB first, byte address.
  - Word index = addr[$clog2(WORDS)+1:2]. addr[1:0] and the upper bits are ignored.
- READ: the word at the index is serialised LSB first (bit 0 first). After 32 bits the index increments by 1, wrapping WORDS-1 to 0, and streaming continues seamlessly.
- WRITE: MOSI bits shift into a 32-bit register LSB first, matching the CPU's right-shifting receiver.
  - On the 32nd bit the word is committed to the current index, then the index increments with the same wrap.
  - A partial word at deselect is discarded.
- IGNORE: spi_data_out held 0 until deselect.
- Deselect (select high) in any state returns to IDLE on that edge. Counters clear; no further commit. This is how the CPU abandons a stream on a taken branch.
- Backdoor load writes mem[load_addr] <= load_data at any time. If it collides with an SPI write commit to the same index in the same cycle, the backdoor load wins.
- Memory contents are not reset.

## Timing
- Reset values: spi_data_out = 0, busy = 0, state IDLE, index 0, bit counter 0.
- Only enabled edges advance bit counters. Edges with spi_clk_enable low hold all state, so the CPU may pause mid-word for multi-cycle instructions.
- Read latency: the enabled edge capturing address bit 23 also registers spi_data_out = mem[index][0]. The CPU therefore samples data bit 0 on the next enabled edge. Each later enabled edge presents the next bit. The edge presenting bit 31 is followed by bit 0 of index+1.
- Word-boundary fetch uses asynchronous array read, so there are no bubbles between words.
- A backdoor load to the word currently being streamed affects only bits not yet presented from the next fetch. The in-flight word is latched at fetch.
- busy rises the edge after select falls and falls the edge select is seen high.
- 32 enabled edges per word; the full read preamble is 32 enabled edges (8 command + 24 address).

## Configuration
- SPI_MEM_WRITE_EN defined: WRITE_CMD decodes to ADDR then WRITE, as above.
- SPI_MEM_WRITE_EN undefined: the WRITE state and the shift/commit logic are compiled out. WRITE_CMD is treated as an unknown command and goes to IGNORE. Memory is writable only by backdoor.

## Test plan
- Reset mid-READ with rstn low for 1 cycle -> spi_data_out = 0, busy = 0 immediately, IDLE; a fresh read then works.
- Backdoor mem[1] = 32'hDEADBEEF, mem[2] = 32'h00000013; send 0x03 + address 0x000004, then 64 enabled edges -> bits EFBEADDE LSB first, then 0x13 LSB first, with no gap.
- Same read with spi_clk_enable low for 5 cycles after bit 10 -> spi_data_out holds bit 10's value throughout; the sequence resumes unchanged.
- Read from address 4*(WORDS-1) for 64 bits -> mem[WORDS-1] then mem[0] (wrap); deselect after bit 40 -> busy drops and spi_data_out = 0 on the next edge.
- With SPI_MEM_WRITE_EN: 0x02 + address 0x000008 + 32'hCAFEF00D LSB first, then 0x03 readback -> 0xCAFEF00D. Deselect after 20 data bits -> mem unchanged. Without the macro: same write -> IGNORE, mem unchanged.
- Command 0x9F -> IGNORE; spi_data_out = 0 for 64 edges; busy stays 1 until deselect.
